program_loader: RTL and testbench

Byte-stream boot loader sitting directly upstream of the single-cycle MIPS datapath. It receives a framed program image over a valid/ready byte interface and writes instruction words into instruction memory and data words into data memory. It holds the CPU in reset until the image is fully written and its checksum verifies, then releases the CPU to fetch from address 0.

---
 rtl/program_loader.sv | 163 ++++++++++++++++
 tb/tb_program_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader for the single-cycle MIPS datapath.
// Receives a framed image (NI/ND header, NI instruction words, ND data words,
// XOR checksum byte) over a valid/ready byte interface. It writes the words
// into instruction and data memory, and holds the CPU in reset until the image
// has loaded and its checksum verifies.
// Ports:
//   clk, rst          clock, async active-high reset
//   start             session start pulse (honoured in IDLE/DONE/ERR)
//   in_data/in_valid  byte stream in; in_ready = loader accepts a byte
//   imem_we/addr/wdata   instruction memory write port (one-cycle strobe)
//   dmem_we/addr/wdata   data memory write port (one-cycle strobe)
//   cpu_rst           1 = datapath held in reset (0 only when DONE)
//   busy, done, err   session status levels
module program_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_IWORD, S_DWORD, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  state_t            state;
  logic [4:0]        flags;     // {in_ready, busy, cpu_rst, done, err}
  logic [1:0]        bcnt;      // byte position within header / word
  logic [23:0]       sh;        // first three bytes of the current word
  logic [15:0]       ni, nd;
  logic [ADDR_W:0]   iidx, didx; // one extra bit so a full memory is legal
  logic [7:0]        csum;
  logic              acc;
  logic [15:0]       nd_full;

  // Status outputs are decoded from the *next* state and registered together
  // with it, so each one changes on the same edge as the state.
  function automatic logic [4:0] flags_of(input state_t s);
    case (s)
      S_HDR, S_IWORD, S_DWORD, S_CSUM: flags_of = 5'b11100;
      S_DONE:                          flags_of = 5'b00010;
      S_ERR:                           flags_of = 5'b00101;
      default:                         flags_of = 5'b00100;
    endcase
  endfunction

  assign {in_ready, busy, cpu_rst, done, err} = flags;
  assign acc     = in_valid && in_ready;
  assign nd_full = {nd[15:8], in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      flags      <= flags_of(S_IDLE);
      bcnt       <= '0;
      sh         <= '0;
      ni         <= '0;
      nd         <= '0;
      iidx       <= '0;
      didx       <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      if (acc && state != S_CSUM) csum <= csum ^ in_data;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_HDR;
            flags <= flags_of(S_HDR);
            bcnt  <= '0;
            iidx  <= '0;
            didx  <= '0;
            csum  <= '0;
          end
        end
        S_HDR: if (acc) begin
          bcnt <= bcnt + 2'd1;
          case (bcnt)
            2'd0: ni[15:8] <= in_data;
            2'd1: ni[7:0]  <= in_data;
            2'd2: nd[15:8] <= in_data;
            default: begin
              nd <= nd_full;
              if (32'(ni) > MAX_WORDS || 32'(nd_full) > MAX_WORDS) begin
                state <= S_ERR;   flags <= flags_of(S_ERR);
              end else if (ni != 16'd0) begin
                state <= S_IWORD; flags <= flags_of(S_IWORD);
              end else if (nd_full != 16'd0) begin
                state <= S_DWORD; flags <= flags_of(S_DWORD);
              end else begin
                state <= S_CSUM;  flags <= flags_of(S_CSUM);
              end
            end
          endcase
        end
        S_IWORD: if (acc) begin
          bcnt <= bcnt + 2'd1;
          sh   <= {sh[15:0], in_data};
          if (bcnt == 2'd3) begin
            imem_we    <= 1'b1;
            imem_addr  <= iidx[ADDR_W-1:0];
            imem_wdata <= {sh, in_data};
            iidx       <= iidx + 1'b1;
            if (32'(iidx) + 32'd1 == 32'(ni)) begin
              if (nd != 16'd0) begin
                state <= S_DWORD; flags <= flags_of(S_DWORD);
              end else begin
                state <= S_CSUM;  flags <= flags_of(S_CSUM);
              end
            end
          end
        end
        S_DWORD: if (acc) begin
          bcnt <= bcnt + 2'd1;
          sh   <= {sh[15:0], in_data};
          if (bcnt == 2'd3) begin
            dmem_we    <= 1'b1;
            dmem_addr  <= didx[ADDR_W-1:0];
            dmem_wdata <= {sh, in_data};
            didx       <= didx + 1'b1;
            if (32'(didx) + 32'd1 == 32'(nd)) begin
              state <= S_CSUM; flags <= flags_of(S_CSUM);
            end
          end
        end
        S_CSUM: if (acc) begin
          if (in_data == csum) begin
            state <= S_DONE; flags <= flags_of(S_DONE);
          end else begin
            state <= S_ERR;  flags <= flags_of(S_ERR);
          end
        end
        default: begin
          state <= S_IDLE;
          flags <= flags_of(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued as
// frames are built and popped as the DUT strobes them. A second instance with
// ADDR_W=2 shares the stimulus for the oversized-header case.
module tb_program_loader;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        in_ready, imem_we, dmem_we, cpu_rst, busy, done, err;
  logic [9:0]  imem_addr, dmem_addr;
  logic [31:0] imem_wdata, dmem_wdata;

  logic        b_in_ready, b_imem_we, b_dmem_we, b_cpu_rst, b_busy, b_done, b_err;
  logic [1:0]  b_imem_addr, b_dmem_addr;
  logic [31:0] b_imem_wdata, b_dmem_wdata;

  program_loader #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err));

  program_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
    .imem_wdata(b_imem_wdata), .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr),
    .dmem_wdata(b_dmem_wdata), .cpu_rst(b_cpu_rst), .busy(b_busy), .done(b_done),
    .err(b_err));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic        d;
    logic [9:0]  a;
    logic [31:0] w;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  fb[$];
  logic [31:0] wlist[$];
  int          b_cnt = 0;

  // Write monitor for the main instance.
  always @(negedge clk) begin : mon
    wr_t e;
    if (imem_we || dmem_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_sel",  {63'd0, dmem_we}, {63'd0, e.d});
        chk("wr_addr", dmem_we ? dmem_addr : imem_addr, e.a);
        chk("wr_data", dmem_we ? dmem_wdata : imem_wdata, e.w);
      end
    end
    if (b_imem_we || b_dmem_we) b_cnt++;
  end

  task automatic make_frame(input int ni, input int nd, input logic [7:0] bad, input bit push);
    logic [7:0] x;
    logic [15:0] n1, n2;
    wr_t e;
    n1 = 16'(ni); n2 = 16'(nd);
    fb = {};
    fb.push_back(n1[15:8]); fb.push_back(n1[7:0]);
    fb.push_back(n2[15:8]); fb.push_back(n2[7:0]);
    for (int i = 0; i < wlist.size(); i++) begin
      for (int k = 3; k >= 0; k--) fb.push_back(wlist[i][k*8 +: 8]);
      if (push) begin
        e.d = (i >= ni);
        e.a = 10'((i >= ni) ? i - ni : i);
        e.w = wlist[i];
        exp_q.push_back(e);
      end
    end
    x = 8'h00;
    foreach (fb[i]) x = x ^ fb[i];
    fb.push_back(x ^ bad);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom);
    end
    @(negedge clk); in_valid = 1'b1; in_data = b; t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (t == 20) chk("ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); in_valid = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_frame(input bit gapped, input int stpos, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      if (i == stpos) begin
        pulse_start();
        chk("midstart_busy", busy, 1);
        chk("midstart_ready", in_ready, 1);
      end
      send(fb[i], gapped ? int'($urandom_range(0, 3)) : 0);
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  initial begin
    int snap;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", {imem_addr, dmem_addr}, 0);
    chk("rst_wdata", {imem_wdata, dmem_wdata}, 0);
    @(negedge clk); rst = 1'b0;

    // Good NI=2, ND=1 frame, back-to-back bytes.
    wlist = {32'h20080005, 32'h2009000A, 32'hDEADBEEF};
    make_frame(2, 1, 8'h00, 1);
    pulse_start();
    chk("start_busy", busy, 1);
    send_frame(0, -1, fb.size());
    chk("good_done", done, 1);
    chk("good_cpu_rst", cpu_rst, 0);
    chk("good_err", err, 0);
    chk("good_busy", busy, 0);
    chk("good_q_empty", exp_q.size(), 0);

    // Corrupted checksum: writes still happen, session fails.
    make_frame(2, 1, 8'h01, 1);
    pulse_start();
    chk("bad_pre_cpu_rst", cpu_rst, 1);
    send_frame(0, -1, fb.size());
    chk("bad_err", err, 1);
    chk("bad_done", done, 0);
    chk("bad_cpu_rst", cpu_rst, 1);
    chk("bad_q_empty", exp_q.size(), 0);

    // Oversized header on ADDR_W=2 instance.
    wlist = {};
    make_frame(5, 0, 8'h00, 0);
    snap = b_cnt;
    pulse_start();
    send_frame(0, -1, 4);
    chk("hdr_err", b_err, 1);
    chk("hdr_in_ready", b_in_ready, 0);
    chk("hdr_busy", b_busy, 0);
    repeat (3) @(negedge clk);
    chk("hdr_no_strobes", b_cnt - snap, 0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;

    // Empty image, then restart from DONE.
    wlist = {};
    make_frame(0, 0, 8'h00, 1);
    chk("empty_csum", fb[4], 0);
    pulse_start();
    send_frame(0, -1, fb.size());
    chk("empty_done", done, 1);
    chk("empty_cpu_rst", cpu_rst, 0);
    pulse_start();
    chk("restart_done", done, 0);
    chk("restart_cpu_rst", cpu_rst, 1);
    chk("restart_busy", busy, 1);
    send_frame(0, -1, fb.size());
    chk("empty2_done", done, 1);

    // Gapped NI=2 frame with an ignored mid-frame start.
    wlist = {32'h20080005, 32'h2009000A, 32'hDEADBEEF};
    make_frame(2, 1, 8'h00, 1);
    pulse_start();
    send_frame(1, 6, fb.size());
    chk("gap_done", done, 1);
    chk("gap_q_empty", exp_q.size(), 0);

    // Reset after 2nd byte of instruction word 1; only word 0 is written.
    make_frame(2, 1, 8'h00, 0);
    exp_q.push_back('{d: 1'b0, a: 10'd0, w: 32'h20080005});
    pulse_start();
    send_frame(0, -1, 10);
    rst = 1'b1; #1;
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cpu_rst", cpu_rst, 1);
    chk("mid_rst_we", {imem_we, dmem_we}, 0);
    chk("mid_rst_addr", {imem_addr, imem_wdata}, 0);
    chk("mid_rst_q_empty", exp_q.size(), 0);
    @(negedge clk); rst = 1'b0;
    wlist = {32'h11223344, 32'h55667788, 32'h99AABBCC};
    make_frame(2, 1, 8'h00, 1);
    pulse_start();
    send_frame(0, -1, fb.size());
    chk("reload_done", done, 1);
    chk("reload_q_empty", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
